mudi_iter: RTL and testbench
============================

Name: mudi_iter

Overview:
- Parametrised multi-cycle HI/LO multiply/divide unit for the MIPS EX stage. Successor to the fixed-latency 32-bit unit.
- Adds a WIDTH parameter, a true iterative restoring divider, multiply-accumulate ops (madd/maddu/msub/msubu) and defined divide-by-zero results.
- Adds a cancel input for exception flush and a one-cycle done pulse.
- HI/LO commit only on completion; control stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4).
- MUL_LAT, 5, multiply busy cycles (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  issue op this cycle (honoured only when busy=0)
- op  in  4  operation code (see package)
- cancel  in  1  abort in-flight op (exception flush)
- src1  in  WIDTH  rs value / dividend / mthi-mtlo data
- src2  in  WIDTH  rt value / divisor
- busy  out  1  op in flight
- done  out  1  one-cycle pulse when a mul/div result commits
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE, all counters and working registers cleared. Applies mid-operation; the in-flight op is lost.
- FSM states: IDLE, MUL, DIV, DFIX.
- Issue: start=1 and busy=0 in cycle T. start while busy=1 is ignored (no queueing). Undefined op codes are no-ops.
- MTHI/MTLO:
  - hi (resp. lo) <= src1 at edge T; visible in T+1.
  - No busy, no done.
- MULT/MULTU/MADD/MADDU/MSUB/MSUBU:
  - 2W-bit product latched at edge T: signed for MULT/MADD/MSUB, zero-extended for the U forms.
  - busy=1 in cycles T+1..T+MUL_LAT.
  - Commit at edge ending T+MUL_LAT: {hi,lo} <= P for MULT(U); {hi,lo} + P for MADD(U); {hi,lo} - P for MSUB(U).
  - Arithmetic is modulo 2^(2W).
  - In T+MUL_LAT+1: busy=0, done=1, new hi/lo visible.
- DIV/DIVU:
  - Edge T: latch magnitudes (signed: absolute values; MIN taken as unsigned 2^(W-1)) and signs; enter DIV.
  - Edges T+1..T+WIDTH: one restoring quotient bit per edge, MSB first, via the sub-module.
  - Edge T+WIDTH+1 (DFIX): apply signs. Quotient is negated if the operand signs differ; remainder takes the dividend's sign. Then commit hi<=rem, lo<=quot.
  - busy=1 in T+1..T+WIDTH+1; done=1 and results visible in T+WIDTH+2.
- Divide by zero: normal latency; hi=src1 (dividend), lo=all ones, for both signed and unsigned.
- Signed MIN / -1 gives lo=MIN, hi=0, with no trap.
- cancel:
  - When busy=1, at the next edge: FSM=IDLE, busy=0, hi/lo unchanged, no done.
  - With busy=0, cancel has no effect. If start is also high, cancel wins and the op is dropped, including MTHI/MTLO.
- Operands are latched at issue; src1/src2 changes during busy are ignored.
- Back-to-back: start may be accepted in the done cycle (busy=0). The accumulate ops then read the just-committed hi/lo.
- hi/lo are stable throughout busy.

Decomposition:
- Package mudi_pkg holds:
  - op codes: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5, OP_MADD=6, OP_MADDU=7, OP_MSUB=8, OP_MSUBU=9
  - FSM state encodings
- Sub-module mudi_div_core(WIDTH): restoring divider.
  - Inputs: load, step, unsigned dividend/divisor magnitudes.
  - Outputs: quotient and remainder magnitudes.
- Top level holds the FSM, counter, sign handling, multiplier, accumulation and HI/LO.

Test Plan (WIDTH=32, MUL_LAT=5):
- MULT src1=0xFFFFFFFE (-2), src2=3 -> busy for 5 cycles, done in cycle 6; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x2, lo=0xFFFFFFFA.
- DIV src1=-7 (0xFFFFFFF9), src2=2 -> busy for 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIV src1=0x80000000, src2=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> hi=5, lo=0xFFFFFFFF.
- MTHI 0x10, MTLO 0x20 (busy=0, no done); then MADD 3*4 -> hi=0x10, lo=0x2C. Then MSUBU 1*0x2D -> hi=0xF, lo=0xFFFFFFFF.
- DIV issued, cancel at 10th busy cycle -> busy=0 next cycle, hi/lo unchanged, no done. A start during busy (MTLO 0x99) -> ignored, lo unchanged.
- Reset asserted mid-MULT -> next cycle hi=lo=0, busy=0, done=0. Back-to-back MULT issued in the done cycle -> accepted, busy again for 5 cycles.

Source files
------------

// File: rtl/mudi_pkg.sv
// rtl/mudi_pkg.sv - op codes and FSM states for the iterative HI/LO multiply/divide unit
package mudi_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DFIX = 2'd3
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] code);
        return (code == OP_MULT)  || (code == OP_MULTU) ||
               (code == OP_MADD)  || (code == OP_MADDU) ||
               (code == OP_MSUB)  || (code == OP_MSUBU);
    endfunction

    function automatic logic is_signed_mul(input logic [3:0] code);
        return (code == OP_MULT) || (code == OP_MADD) || (code == OP_MSUB);
    endfunction

endpackage

// File: rtl/mudi_div_core.sv
// rtl/mudi_div_core.sv - unsigned restoring divider, one quotient bit per step, MSB first
module mudi_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // quo_q doubles as the dividend shift register; quotient bits enter at the LSB
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quot_o = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/mudi_iter.sv
// rtl/mudi_iter.sv - multi-cycle HI/LO multiply/accumulate/divide unit with cancel and done pulse
module mudi_iter
    import mudi_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [3:0]         op_q;
    logic               qneg_q, rneg_q, divz_q;
    logic [WIDTH-1:0]   dvd_q;

    logic [2*WIDTH-1:0] a_ext, b_ext, product, acc_d;
    logic               div_signed, issue, div_load;
    logic [WIDTH-1:0]   mag1, mag2, quot_mag, rem_mag, quot_fix, rem_fix;

    always_comb begin
        a_ext = is_signed_mul(op) ? {{WIDTH{src1[WIDTH-1]}}, src1} : {{WIDTH{1'b0}}, src1};
        b_ext = is_signed_mul(op) ? {{WIDTH{src2[WIDTH-1]}}, src2} : {{WIDTH{1'b0}}, src2};
        product = a_ext * b_ext;
        // signed MIN negates to itself, which is exactly its unsigned magnitude
        div_signed = (op == OP_DIV);
        mag1 = (div_signed && src1[WIDTH-1]) ? -src1 : src1;
        mag2 = (div_signed && src2[WIDTH-1]) ? -src2 : src2;
        case (op_q)
            OP_MADD, OP_MADDU: acc_d = {hi_q, lo_q} + prod_q;
            OP_MSUB, OP_MSUBU: acc_d = {hi_q, lo_q} - prod_q;
            default:           acc_d = prod_q;
        endcase
        quot_fix = qneg_q ? -quot_mag : quot_mag;
        rem_fix  = rneg_q ? -rem_mag  : rem_mag;
    end

    assign issue    = (state_q == ST_IDLE) && start && !cancel;
    assign div_load = issue && ((op == OP_DIV) || (op == OP_DIVU));

    mudi_div_core #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .reset      (reset),
        .load_i     (div_load),
        .step_i     (state_q == ST_DIV),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .quot_o     (quot_mag),
        .rem_o      (rem_mag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
            op_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
            dvd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        op_q <= op;
                        if (op == OP_MTHI) begin
                            hi_q <= src1;
                        end else if (op == OP_MTLO) begin
                            lo_q <= src1;
                        end else if (is_mul_op(op)) begin
                            prod_q  <= product;
                            cnt_q   <= CW'(MUL_LAT - 1);
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                        end else if (div_load) begin
                            qneg_q  <= div_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                            rneg_q  <= div_signed && src1[WIDTH-1];
                            divz_q  <= (src2 == '0);
                            dvd_q   <= src1;
                            cnt_q   <= CW'(WIDTH - 1);
                            state_q <= ST_DIV;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        {hi_q, lo_q} <= acc_d;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DIV: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_DFIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DFIX: begin
                    if (!cancel) begin
                        hi_q   <= divz_q ? dvd_q : rem_fix;
                        lo_q   <= divz_q ? '1    : quot_fix;
                        done_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mudi_iter.sv
// tb/tb_mudi_iter.sv - randomized self-checking bench for mudi_iter against an arithmetic reference model
module tb_mudi_iter;
    import mudi_pkg::*;

    localparam int W  = 32;
    localparam int ML = 5;

    logic         clk = 1'b0;
    logic         reset, start, cancel;
    logic [3:0]   op;
    logic [W-1:0] src1, src2, hi, lo;
    logic         busy, done;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] m_hi, m_lo;

    mudi_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .cancel (cancel),
        .src1   (src1),
        .src2   (src2),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return ML;
            OP_DIV, OP_DIVU: return W + 1;
            default: return 0;
        endcase
    endfunction

    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] acc, sp, up;
        int          ia, ib;
        longint      q, r;
        ia  = a;
        ib  = b;
        acc = {m_hi, m_lo};
        sp  = longint'(ia) * longint'(ib);
        up  = {32'h0, a} * {32'h0, b};
        case (o)
            OP_MTHI:  m_hi = a;
            OP_MTLO:  m_lo = a;
            OP_MULT:  {m_hi, m_lo} = sp;
            OP_MULTU: {m_hi, m_lo} = up;
            OP_MADD:  {m_hi, m_lo} = acc + sp;
            OP_MADDU: {m_hi, m_lo} = acc + up;
            OP_MSUB:  {m_hi, m_lo} = acc - sp;
            OP_MSUBU: {m_hi, m_lo} = acc - up;
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = '1;
                end else if (o == OP_DIV) begin
                    q = longint'(ia) / longint'(ib);
                    r = longint'(ia) % longint'(ib);
                    m_lo = W'(q);
                    m_hi = W'(r);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after completion.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int           n, lat;
        logic [W-1:0] h0, l0;
        logic         moved;
        lat   = exp_lat(o);
        h0    = hi;
        l0    = lo;
        moved = 1'b0;
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        n = 0;
        while (busy && n < 100) begin
            if (hi !== h0 || lo !== l0) moved = 1'b1;
            @(negedge clk);
            n++;
        end
        model(o, a, b);
        check("latency", n, lat);
        check("done", done, lat != 0);
        if (lat != 0) check("hilo_stable", moved, 1'b0);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    // Issues o, ignores a stray MTLO start mid-flight, cancels at the k-th busy cycle (k >= 3).
    task automatic run_cancel(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < k; i++) begin
            if (i == 2) begin
                op = OP_MTLO; src1 = 32'h99; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_before_cancel", busy, 1'b1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy, 1'b0);
        check("cancel_done", done, 1'b0);
        check("cancel_hi", hi, m_hi);
        check("cancel_lo", lo, m_lo);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] o;
        int         lat;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src1 = '0; src2 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_c", hi, 32'hFFFF_FFFF);
        check("mult_lo_c", lo, 32'hFFFF_FFFA);
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi_c", hi, 32'h2);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_c", lo, 32'hFFFF_FFFD);
        check("div_hi_c", hi, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd100, 32'd7);
        check("divu_lo_c", lo, 32'd14);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("minneg1_lo_c", lo, 32'h8000_0000);
        check("minneg1_hi_c", hi, 32'h0);
        run_op(OP_DIVU, 32'd5, 32'd0);
        check("divz_hi_c", hi, 32'd5);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        run_op(OP_MTHI, 32'h10, 32'h0);
        run_op(OP_MTLO, 32'h20, 32'h0);
        run_op(OP_MADD, 32'd3, 32'd4);
        check("madd_lo_c", lo, 32'h2C);
        run_op(OP_MSUBU, 32'd1, 32'h2D);
        check("msubu_hi_c", hi, 32'hF);
        check("msubu_lo_c", lo, 32'hFFFF_FFFF);

        run_cancel(OP_DIV, 32'd1000, 32'd3, 10);
        run_cancel(OP_MADD, 32'd7, 32'd9, ML);

        op = OP_MTHI; src1 = 32'hDEAD; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("idle_cancel_hi", hi, m_hi);

        op = OP_MULT; src1 = 32'd6; src2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);

        run_op(OP_MULT, 32'd6, 32'd7);
        run_op(OP_MULT, 32'hFFFF_FFF0, 32'd5);

        for (int it = 0; it < 60; it++) begin
            o   = 4'($urandom_range(0, 15));
            lat = exp_lat(o);
            if (lat != 0 && $urandom_range(0, 5) == 0)
                run_cancel(o, rnd_val(), rnd_val(), $urandom_range(3, lat));
            else
                run_op(o, rnd_val(), rnd_val());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
